// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the SPI slave, the local host port and the single-port RAM.
// The arbiter is the slave side; whoever drives SPI words, host requests and RAM read data is the master side.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 rx_valid;
  logic [9:0]           rx_data;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 lcl_req;
  logic                 lcl_we;
  logic [ADDR_SIZE-1:0] lcl_addr;
  logic [7:0]           lcl_wdata;
  logic                 lcl_gnt;
  logic                 lcl_rvalid;
  logic [7:0]           lcl_rdata;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
  logic                 spi_ovf;

  modport slave (
    input  rx_valid, rx_data, lcl_req, lcl_we, lcl_addr, lcl_wdata, ram_rdata,
    output tx_valid, tx_data, lcl_gnt, lcl_rvalid, lcl_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );

  modport master (
    output rx_valid, rx_data, lcl_req, lcl_we, lcl_addr, lcl_wdata, ram_rdata,
    input  tx_valid, tx_data, lcl_gnt, lcl_rvalid, lcl_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Owns a single-port RAM and shares it round-robin between decoded SPI command words
// and a local host port, with one RAM operation in flight at a time.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_arbiter_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  localparam logic RR_SPI = 1'b0;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_rr_ptr;
  logic                   w_rr_nxt;
  logic                   w_gnt_spi;
  logic                   w_gnt_lcl;

  logic [ADDR_SIZE-1:0]   r_wr_addr;
  logic [ADDR_SIZE-1:0]   r_rd_addr;
  logic                   r_pend_valid;
  logic                   r_pend_we;
  logic [ADDR_SIZE-1:0]   r_pend_addr;
  logic [MEM_WIDTH-1:0]   r_pend_wdata;
  logic                   r_spi_ovf;

  logic                   r_owner_lcl;
  logic                   r_ram_en;
  logic                   r_ram_we;
  logic [ADDR_SIZE-1:0]   r_ram_addr;
  logic [MEM_WIDTH-1:0]   r_ram_wdata;
  logic                   r_lcl_gnt;
  logic                   r_tx_valid;
  logic [7:0]             r_tx_data;
  logic                   r_lcl_rvalid;
  logic [7:0]             r_lcl_rdata;

  logic                   w_rx_op;
  logic                   w_rx_accept;
  logic                   w_rx_drop;

  // Commands 01/11 (bit 8 set) post a RAM op; a slot being granted this cycle counts as free.
  assign w_rx_op     = io_bus.rx_valid && io_bus.rx_data[8];
  assign w_rx_accept = w_rx_op && (!r_pend_valid || w_gnt_spi);
  assign w_rx_drop   = w_rx_op && !w_rx_accept;

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= RR_SPI;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Arbitration and next-state; the pointer only moves when both sides compete.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_gnt_spi   = 1'b0;
    w_gnt_lcl   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_valid && io_bus.lcl_req) begin
          if (r_rr_ptr == RR_SPI) begin
            w_gnt_spi = 1'b1;
          end else begin
            w_gnt_lcl = 1'b1;
          end
          w_rr_nxt    = ~r_rr_ptr;
          w_state_nxt = ST_ACCESS;
        end else if (r_pend_valid) begin
          w_gnt_spi   = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else if (io_bus.lcl_req) begin
          w_gnt_lcl   = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_ram_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RDWAIT;
        end
      end
      ST_RDWAIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // SPI decode: address registers, one-deep pending op, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_spi_ovf    <= 1'b0;
    end else begin
      if (io_bus.rx_valid && !io_bus.rx_data[8]) begin
        if (io_bus.rx_data[9]) begin
          r_rd_addr <= ADDR_SIZE'(io_bus.rx_data[7:0]);
        end else begin
          r_wr_addr <= ADDR_SIZE'(io_bus.rx_data[7:0]);
        end
      end
      // The address is frozen at post time so later 00/10 words cannot retarget it.
      if (w_rx_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_we    <= !io_bus.rx_data[9];
        r_pend_addr  <= io_bus.rx_data[9] ? r_rd_addr : r_wr_addr;
        r_pend_wdata <= MEM_WIDTH'(io_bus.rx_data[7:0]);
      end else if (w_gnt_spi) begin
        r_pend_valid <= 1'b0;
      end
      if (w_rx_drop) begin
        r_spi_ovf <= 1'b1;
      end
    end
  end

  // RAM port, grant pulse and read-data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_lcl  <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_lcl_gnt    <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_lcl_rvalid <= 1'b0;
      r_lcl_rdata  <= 8'h00;
    end else begin
      r_ram_en  <= w_gnt_spi || w_gnt_lcl;
      r_lcl_gnt <= w_gnt_lcl;
      if (w_gnt_spi) begin
        r_owner_lcl <= 1'b0;
        r_ram_we    <= r_pend_we;
        r_ram_addr  <= r_pend_addr;
        r_ram_wdata <= r_pend_wdata;
      end else if (w_gnt_lcl) begin
        r_owner_lcl <= 1'b1;
        r_ram_we    <= io_bus.lcl_we;
        r_ram_addr  <= io_bus.lcl_addr;
        r_ram_wdata <= MEM_WIDTH'(io_bus.lcl_wdata);
      end
      r_tx_valid   <= (r_state == ST_RDWAIT) && !r_owner_lcl;
      r_lcl_rvalid <= (r_state == ST_RDWAIT) && r_owner_lcl;
      if (r_state == ST_RDWAIT) begin
        if (r_owner_lcl) begin
          r_lcl_rdata <= io_bus.ram_rdata;
        end else begin
          r_tx_data <= io_bus.ram_rdata;
        end
      end
    end
  end

  assign io_bus.tx_valid   = r_tx_valid;
  assign io_bus.tx_data    = r_tx_data;
  assign io_bus.lcl_gnt    = r_lcl_gnt;
  assign io_bus.lcl_rvalid = r_lcl_rvalid;
  assign io_bus.lcl_rdata  = r_lcl_rdata;
  assign io_bus.ram_en     = r_ram_en;
  assign io_bus.ram_we     = r_ram_we;
  assign io_bus.ram_addr   = r_ram_addr;
  assign io_bus.ram_wdata  = 8'(r_ram_wdata);
  assign io_bus.spi_ovf    = r_spi_ovf;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: stimulus pushes expected RAM accesses and read data,
// a negedge monitor pops and compares whenever the arbiter presents an access or a valid pulse.
module tb_spi_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;

  spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // RAM: read data appears the cycle after a read strobe.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  m_wr_addr, m_rd_addr;
  logic [16:0] q_sacc[$];
  logic [16:0] q_lacc[$];
  logic [7:0]  q_tx[$];
  logic [7:0]  q_lrd[$];
  logic [16:0] mon_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event with value 0x%0h, required none", name, act);
  endtask

  // Reference behaviour of one SPI word: address words update the model, op words queue expectations.
  task automatic model_spi(input logic [9:0] w, input bit accepted);
    case (w[9:8])
      2'b00: m_wr_addr = w[7:0];
      2'b01: if (accepted) begin
        q_sacc.push_back({1'b1, m_wr_addr, w[7:0]});
        ref_mem[m_wr_addr] = w[7:0];
      end
      2'b10: m_rd_addr = w[7:0];
      default: if (accepted) begin
        q_sacc.push_back({1'b0, m_rd_addr, 8'h00});
        q_tx.push_back(ref_mem[m_rd_addr]);
      end
    endcase
  endtask

  task automatic model_lcl(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    q_lacc.push_back({we, addr, we ? wdata : 8'h00});
    if (we) ref_mem[addr] = wdata;
    else    q_lrd.push_back(ref_mem[addr]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [9:0] w);
    model_spi(w, 1'b1);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic lcl_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bit got;
    model_lcl(we, addr, wdata);
    @(negedge clk);
    bus.lcl_req   = 1'b1;
    bus.lcl_we    = we;
    bus.lcl_addr  = addr;
    bus.lcl_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.lcl_gnt;
    end
    if (!got) unexpected("lcl_gnt_timeout", 64'(addr));
    bus.lcl_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.tx_valid, bus.tx_data, bus.lcl_gnt, bus.lcl_rvalid, bus.lcl_rdata,
                 bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.spi_ovf}, 64'd0);
  endtask

  // SPI op and local request arrive together in IDLE; exp_lcl_first says who should win.
  task automatic contest(input logic [9:0] w, input logic lwe, input logic [7:0] laddr,
                         input logic [7:0] lwdata, input bit exp_lcl_first);
    bit got;
    int extra;
    model_spi(w, 1'b1);
    model_lcl(lwe, laddr, lwdata);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.lcl_req   = 1'b1;
    bus.lcl_we    = lwe;
    bus.lcl_addr  = laddr;
    bus.lcl_wdata = lwdata;
    @(negedge clk);
    check(exp_lcl_first ? "contest_lcl_first" : "contest_spi_first",
          {bus.ram_en, bus.lcl_gnt}, {1'b1, exp_lcl_first});
    got = bus.lcl_gnt;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.lcl_gnt;
    end
    check("contest_lcl_gnt_seen", got, 1);
    bus.lcl_req = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.lcl_gnt) extra++;
    end
    check("contest_lcl_gnt_once", extra, 0);
  endtask

  // Scoreboard monitor: every access and valid pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.ram_en) begin
        mon_acc = {bus.ram_we, bus.ram_addr, bus.ram_we ? bus.ram_wdata : 8'h00};
        if (bus.lcl_gnt) begin
          if (q_lacc.size() == 0) unexpected("lcl_access", 64'(mon_acc));
          else check("lcl_access", 64'(mon_acc), 64'(q_lacc.pop_front()));
        end else begin
          if (q_sacc.size() == 0) unexpected("spi_access", 64'(mon_acc));
          else check("spi_access", 64'(mon_acc), 64'(q_sacc.pop_front()));
        end
      end else if (bus.lcl_gnt) begin
        unexpected("lcl_gnt_without_ram_en", 64'(bus.lcl_addr));
      end
      if (bus.tx_valid) begin
        if (q_tx.size() == 0) unexpected("tx_valid", 64'(bus.tx_data));
        else check("tx_data", 64'(bus.tx_data), 64'(q_tx.pop_front()));
      end
      if (bus.lcl_rvalid) begin
        if (q_lrd.size() == 0) unexpected("lcl_rvalid", 64'(bus.lcl_rdata));
        else check("lcl_rdata", 64'(bus.lcl_rdata), 64'(q_lrd.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int          lat;
  int          k;
  int          last;
  int          n_tx;
  logic [7:0]  d;

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 10'h000;
    bus.lcl_req   = 1'b0;
    bus.lcl_we    = 1'b0;
    bus.lcl_addr  = 8'h00;
    bus.lcl_wdata = 8'h00;
    mem_clr       = 1'b1;
    rst_n         = 1'b0;
    m_wr_addr     = 8'h00;
    m_rd_addr     = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    idle(2);
    mem_clr = 1'b0;
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    idle(2);

    // Write via SPI, then read back with latency measurement and data hold.
    send_rx(10'h03C);
    send_rx(10'h1A5);
    idle(4);
    send_rx(10'h23C);
    send_rx(10'h300);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.tx_valid) lat = i;
    end
    check("read_latency", lat, 3);
    idle(4);
    check("tx_data_hold", bus.tx_data, 8'hA5);

    // Round-robin: SPI wins first contest, local wins the next.
    send_rx(10'h010);
    send_rx(10'h15A);
    send_rx(10'h020);
    idle(3);
    contest(10'h1C3, 1'b0, 8'h10, 8'h00, 1'b0);
    check("lcl_rdata_hold", bus.lcl_rdata, 8'h5A);
    contest(10'h1D4, 1'b1, 8'h11, 8'h66, 1'b1);

    // Second SPI op while the first is still pending is dropped.
    model_lcl(1'b0, 8'h10, 8'h00);
    @(negedge clk);
    bus.lcl_req  = 1'b1;
    bus.lcl_we   = 1'b0;
    bus.lcl_addr = 8'h10;
    @(negedge clk);
    check("ovf_lcl_gnt", bus.lcl_gnt, 1);
    bus.lcl_req  = 1'b0;
    model_spi(10'h111, 1'b1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 10'h111;
    @(negedge clk);
    model_spi(10'h122, 1'b0);
    bus.rx_data  = 10'h122;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("spi_ovf_set", bus.spi_ovf, 1);
    idle(6);
    check("spi_ovf_sticky", bus.spi_ovf, 1);
    send_rx(10'h220);
    send_rx(10'h300);
    idle(5);

    // Reset while a read waits for RAM data: no pulse, addresses cleared.
    send_rx(10'h000);
    send_rx(10'h177);
    send_rx(10'h23C);
    idle(3);
    q_sacc.push_back({1'b0, 8'h3C, 8'h00});
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 10'h300;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    idle(2);
    rst_n     = 1'b0;
    m_wr_addr = 8'h00;
    m_rd_addr = 8'h00;
    @(negedge clk);
    check_outputs_zero("midop_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    n_tx = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_valid) n_tx++;
    end
    check("no_tx_after_abort", n_tx, 0);
    send_rx(10'h300);
    idle(5);

    // Back-to-back local writes: one grant every two cycles.
    k    = 0;
    last = 0;
    d    = 8'($urandom);
    model_lcl(1'b1, 8'h80, d);
    @(negedge clk);
    bus.lcl_req   = 1'b1;
    bus.lcl_we    = 1'b1;
    bus.lcl_addr  = 8'h80;
    bus.lcl_wdata = d;
    for (int c = 1; c <= 40 && k < 10; c++) begin
      @(negedge clk);
      if (bus.lcl_gnt) begin
        if (k > 0) check("stream_gap", c - last, 2);
        last = c;
        k++;
        if (k < 10) begin
          d = 8'($urandom);
          model_lcl(1'b1, 8'h80 + 8'(k), d);
          bus.lcl_addr  = 8'h80 + 8'(k);
          bus.lcl_wdata = d;
        end else begin
          bus.lcl_req = 1'b0;
        end
      end
    end
    check("stream_count", k, 10);
    check("stream_span", last, 19);
    lcl_op(1'b0, 8'h83, 8'h00);
    idle(4);

    // Random traffic: SPI in 0x00-0x7F, local in 0x80-0xFF, SPI words spaced so none drop.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [1:0] cmd;
          logic [7:0] dat;
          cmd = 2'($urandom_range(0, 3));
          dat = 8'($urandom);
          if (!cmd[0]) dat[7] = 1'b0;
          send_rx({cmd, dat});
          idle($urandom_range(7, 11));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          lcl_op(1'($urandom), 8'h80 | 8'($urandom), 8'($urandom));
          idle($urandom_range(0, 3));
        end
      end
    join
    idle(10);
    check("random_no_ovf", bus.spi_ovf, 0);
    check("spi_access_drained", q_sacc.size(), 0);
    check("lcl_access_drained", q_lacc.size(), 0);
    check("tx_drained", q_tx.size(), 0);
    check("lcl_rdata_drained", q_lrd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
